// File: rtl/commit_pkg.sv
// Shared widths, default sizing and small helpers for the commit stage.
package commit_pkg;

  localparam int DATA_W          = 64;
  localparam int RN_W            = 6;
  localparam int NUM_UNITS_DEF   = 5;
  localparam int NUM_WPORTS_DEF  = 2;
  localparam int DEFER_DEPTH_DEF = 4;

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/commit_mp_if.sv
// Execution-unit result channels and register-file write ports of the commit stage.
interface commit_mp_if #(
  parameter int NUM_UNITS  = commit_pkg::NUM_UNITS_DEF,
  parameter int NUM_WPORTS = commit_pkg::NUM_WPORTS_DEF,
  parameter int DATA_W     = commit_pkg::DATA_W,
  parameter int RN_W       = commit_pkg::RN_W
);

  logic [NUM_UNITS-1:0]         unit_valid;
  logic [NUM_UNITS-1:0]         unit_ready;
  logic [NUM_UNITS*DATA_W-1:0]  unit_data;
  logic [NUM_UNITS*RN_W-1:0]    unit_rn;
  logic [NUM_UNITS-1:0]         unit_dual;
  logic [NUM_UNITS*DATA_W-1:0]  unit_data2;
  logic [NUM_UNITS*RN_W-1:0]    unit_rn2;
  logic [NUM_WPORTS-1:0]        wr_en;
  logic [NUM_WPORTS*DATA_W-1:0] wr_data;
  logic [NUM_WPORTS*RN_W-1:0]   wr_rn;

  modport master (
    output unit_valid, unit_data, unit_rn, unit_dual, unit_data2, unit_rn2,
    input  unit_ready, wr_en, wr_data, wr_rn
  );

  modport slave (
    input  unit_valid, unit_data, unit_rn, unit_dual, unit_data2, unit_rn2,
    output unit_ready, wr_en, wr_data, wr_rn
  );

endinterface

// File: rtl/commit_defer_fifo.sv
// Deferred-write FIFO holding second results; up to NPORT pushes and pops per cycle.
module commit_defer_fifo #(
  parameter int DEPTH  = commit_pkg::DEFER_DEPTH_DEF,
  parameter int DATA_W = commit_pkg::DATA_W,
  parameter int RN_W   = commit_pkg::RN_W,
  parameter int NPORT  = commit_pkg::NUM_WPORTS_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1,
  localparam int PCW   = $clog2(NPORT + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [PCW-1:0]               pop_cnt,
  input  logic [NPORT-1:0]             push_en,
  input  logic [NPORT-1:0][DATA_W-1:0] push_data,
  input  logic [NPORT-1:0][RN_W-1:0]   push_rn,
  output logic [NPORT-1:0][DATA_W-1:0] head_data,
  output logic [NPORT-1:0][RN_W-1:0]   head_rn,
  output logic [CNT_W-1:0]             count
);
  import commit_pkg::*;

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [RN_W-1:0]   mem_rn   [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [PTR_W-1:0]  push_slot [NPORT];
  logic [CNT_W-1:0]  push_total;

  // Active pushes are packed into consecutive slots in port order.
  always_comb begin
    int n;
    n = 0;
    for (int p = 0; p < NPORT; p++) begin
      push_slot[p] = wr_ptr + PTR_W'(n);
      if (push_en[p]) n++;
    end
    push_total = CNT_W'(n);
  end

  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      head_data[p] = mem_data[rd_ptr + PTR_W'(p)];
      head_rn[p]   = mem_rn[rd_ptr + PTR_W'(p)];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_rn[i]   <= '0;
      end
    end else begin
      for (int p = 0; p < NPORT; p++) begin
        if (push_en[p]) begin
          mem_data[push_slot[p]] <= push_data[p];
          mem_rn[push_slot[p]]   <= push_rn[p];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PTR_W'(pop_cnt);
      wr_ptr <= wr_ptr + PTR_W'(push_total);
      count  <= count - CNT_W'(pop_cnt) + push_total;
    end
  end

endmodule

// File: rtl/commit_mp.sv
// Commit stage: drains deferred writes first, then round-robin grants result channels to free ports.
module commit_mp #(
  parameter int NUM_UNITS   = commit_pkg::NUM_UNITS_DEF,
  parameter int NUM_WPORTS  = commit_pkg::NUM_WPORTS_DEF,
  parameter int DATA_W      = commit_pkg::DATA_W,
  parameter int RN_W        = commit_pkg::RN_W,
  parameter int DEFER_DEPTH = commit_pkg::DEFER_DEPTH_DEF,
  localparam int CNT_W      = $clog2(DEFER_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  commit_mp_if.slave       bus,
  output logic [CNT_W-1:0] defer_count
);
  import commit_pkg::*;

  localparam int UNIT_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int PCW    = $clog2(NUM_WPORTS + 1);

  logic [UNIT_W-1:0]                 rr_ptr, last_ch;
  logic                              grant_any;
  logic [NUM_UNITS-1:0]              ready;
  logic [NUM_WPORTS-1:0]             wen;
  logic [NUM_WPORTS*DATA_W-1:0]      wdata;
  logic [NUM_WPORTS*RN_W-1:0]        wrn;
  logic [PCW-1:0]                    pop_cnt;
  logic [NUM_WPORTS-1:0]             push_en;
  logic [NUM_WPORTS-1:0][DATA_W-1:0] push_data, head_data;
  logic [NUM_WPORTS-1:0][RN_W-1:0]   push_rn, head_rn;
  logic [CNT_W-1:0]                  fifo_count;

  commit_defer_fifo #(
    .DEPTH (DEFER_DEPTH),
    .DATA_W(DATA_W),
    .RN_W  (RN_W),
    .NPORT (NUM_WPORTS)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .pop_cnt  (pop_cnt),
    .push_en  (push_en),
    .push_data(push_data),
    .push_rn  (push_rn),
    .head_data(head_data),
    .head_rn  (head_rn),
    .count    (fifo_count)
  );

  // A blocked dual or a full port set ends the scan so later channels cannot overtake.
  always_comb begin
    int n_pop, port, duals, ch;
    logic stop;
    logic [RN_W-1:0] rn;
    ready     = '0;
    wen       = '0;
    wdata     = '0;
    wrn       = '0;
    push_en   = '0;
    push_data = '0;
    push_rn   = '0;
    grant_any = 1'b0;
    last_ch   = '0;
    stop      = 1'b0;
    n_pop     = 0;
    port      = 0;
    duals     = 0;
    ch        = 0;
    rn        = '0;
    if (rst_n) begin
      n_pop = min_int(int'(fifo_count), NUM_WPORTS);
      for (int p = 0; p < NUM_WPORTS; p++) begin
        if (p < n_pop) begin
          wrn[p*RN_W +: RN_W]       = head_rn[p];
          wdata[p*DATA_W +: DATA_W] = head_data[p];
          wen[p]                    = |head_rn[p];
        end
      end
      port = n_pop;
      for (int k = 0; k < NUM_UNITS; k++) begin
        ch = (int'(rr_ptr) + k) % NUM_UNITS;
        if (!stop && bus.unit_valid[ch]) begin
          if (port >= NUM_WPORTS) begin
            stop = 1'b1;
          end else if (bus.unit_dual[ch] &&
                       (int'(fifo_count) - n_pop + duals >= DEFER_DEPTH)) begin
            stop = 1'b1;
          end else begin
            rn                           = bus.unit_rn[ch*RN_W +: RN_W];
            ready[ch]                    = 1'b1;
            wrn[port*RN_W +: RN_W]       = rn;
            wdata[port*DATA_W +: DATA_W] = bus.unit_data[ch*DATA_W +: DATA_W];
            wen[port]                    = |rn;
            if (bus.unit_dual[ch]) begin
              push_en[port]   = 1'b1;
              push_data[port] = bus.unit_data2[ch*DATA_W +: DATA_W];
              push_rn[port]   = bus.unit_rn2[ch*RN_W +: RN_W];
              duals++;
            end
            grant_any = 1'b1;
            last_ch   = UNIT_W'(ch);
            port++;
          end
        end
      end
    end
    pop_cnt = PCW'(n_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= (int'(last_ch) == NUM_UNITS - 1) ? '0 : last_ch + 1'b1;
    end
  end

  assign bus.unit_ready = ready;
  assign bus.wr_en      = wen;
  assign bus.wr_data    = wdata;
  assign bus.wr_rn      = wrn;
  assign defer_count    = fifo_count;

endmodule

// File: tb/tb_commit_mp.sv
// Scoreboard bench: default-sized DUT (A) plus a 4-port/2-deep DUT (B) sharing random stimulus.
module tb_commit_mp;

  localparam int NU = 5;

  typedef struct packed {
    logic [5:0]  rn;
    logic [63:0] data;
  } entry_t;

  typedef struct packed {
    logic             rst;
    logic [4:0]       ready;
    logic [3:0]       wen;
    logic [3:0]       used;
    logic [3:0][63:0] wdata;
    logic [3:0][5:0]  wrn;
    int               count;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] defer_a;
  logic [1:0] defer_b;

  always #5 clk = ~clk;

  commit_mp_if #(.NUM_UNITS(NU), .NUM_WPORTS(2), .DATA_W(64), .RN_W(6)) bus_a ();
  commit_mp_if #(.NUM_UNITS(NU), .NUM_WPORTS(4), .DATA_W(64), .RN_W(6)) bus_b ();

  commit_mp #(.NUM_UNITS(NU), .NUM_WPORTS(2), .DATA_W(64), .RN_W(6), .DEFER_DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave), .defer_count(defer_a)
  );

  commit_mp #(.NUM_UNITS(NU), .NUM_WPORTS(4), .DATA_W(64), .RN_W(6), .DEFER_DEPTH(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave), .defer_count(defer_b)
  );

  logic        sv   [NU];
  logic        sd   [NU];
  logic [63:0] sdat [NU];
  logic [63:0] sdat2[NU];
  logic [5:0]  srn  [NU];
  logic [5:0]  srn2 [NU];
  logic        rst_drv;

  entry_t mq [2][16];
  int     mn [2];
  int     mrr[2];

  exp_t exp_a[$];
  exp_t exp_b[$];

  int checks = 0;
  int errors = 0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: deferred writes kept as an ordered list, channels scanned from the RR pointer.
  task automatic modelCycle(input int inst, input int nwp, input int depth, output exp_t e);
    entry_t sec[4];
    int pops, port, nsec, last, ch;
    e = '0;
    if (!rst_drv) begin
      mn[inst]  = 0;
      mrr[inst] = 0;
      e.rst     = 1'b1;
      return;
    end
    e.count = mn[inst];
    pops = (mn[inst] < nwp) ? mn[inst] : nwp;
    for (int p = 0; p < pops; p++) begin
      e.used[p]  = 1'b1;
      e.wrn[p]   = mq[inst][p].rn;
      e.wdata[p] = mq[inst][p].data;
      e.wen[p]   = (mq[inst][p].rn != 0);
    end
    port = pops;
    nsec = 0;
    last = -1;
    for (int k = 0; k < NU; k++) begin
      ch = (mrr[inst] + k) % NU;
      if (!sv[ch]) continue;
      if (port >= nwp) break;
      if (sd[ch] && (mn[inst] - pops + nsec >= depth)) break;
      e.ready[ch]   = 1'b1;
      e.used[port]  = 1'b1;
      e.wrn[port]   = srn[ch];
      e.wdata[port] = sdat[ch];
      e.wen[port]   = (srn[ch] != 0);
      if (sd[ch]) begin
        sec[nsec] = '{rn: srn2[ch], data: sdat2[ch]};
        nsec++;
      end
      last = ch;
      port++;
    end
    for (int i = 0; i < mn[inst] - pops; i++) mq[inst][i] = mq[inst][i + pops];
    mn[inst] -= pops;
    for (int j = 0; j < nsec; j++) begin
      mq[inst][mn[inst]] = sec[j];
      mn[inst]++;
    end
    if (last >= 0) mrr[inst] = (last + 1) % NU;
  endtask

  task automatic applyStimulus();
    exp_t ea, eb;
    @(posedge clk);
    #1;
    rst_n = rst_drv;
    for (int i = 0; i < NU; i++) begin
      bus_a.unit_valid[i] = sv[i];
      bus_a.unit_dual[i]  = sd[i];
      bus_a.unit_data[i*64 +: 64]  = sdat[i];
      bus_a.unit_data2[i*64 +: 64] = sdat2[i];
      bus_a.unit_rn[i*6 +: 6]      = srn[i];
      bus_a.unit_rn2[i*6 +: 6]     = srn2[i];
      bus_b.unit_valid[i] = sv[i];
      bus_b.unit_dual[i]  = sd[i];
      bus_b.unit_data[i*64 +: 64]  = sdat[i];
      bus_b.unit_data2[i*64 +: 64] = sdat2[i];
      bus_b.unit_rn[i*6 +: 6]      = srn[i];
      bus_b.unit_rn2[i*6 +: 6]     = srn2[i];
    end
    modelCycle(0, 2, 4, ea);
    modelCycle(1, 4, 2, eb);
    exp_a.push_back(ea);
    exp_b.push_back(eb);
  endtask

  task automatic checkOutput(input string tag, input int nwp, input exp_t e,
                             input logic [4:0] rdy, input logic [3:0] wen,
                             input logic [3:0][63:0] wd, input logic [3:0][5:0] wr,
                             input int cnt);
    cmp({tag, ".unit_ready"}, 64'(rdy), 64'(e.ready));
    cmp({tag, ".wr_en"}, 64'(wen), 64'(e.wen));
    cmp({tag, ".defer_count"}, 64'(cnt), 64'(e.count));
    if (!e.rst) begin
      for (int p = 0; p < nwp; p++) begin
        if (e.wen[p]) begin
          cmp($sformatf("%s.wr_rn[%0d]", tag, p), 64'(wr[p]), 64'(e.wrn[p]));
          cmp($sformatf("%s.wr_data[%0d]", tag, p), wd[p], e.wdata[p]);
        end else if (!e.used[p]) begin
          cmp($sformatf("%s.idle_rn[%0d]", tag, p), 64'(wr[p]), 64'd0);
          cmp($sformatf("%s.idle_data[%0d]", tag, p), wd[p], 64'd0);
        end
      end
    end
  endtask

  // Monitor: compares whatever the DUTs present against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      checkOutput("A", 2, e, bus_a.unit_ready, {2'b00, bus_a.wr_en},
                  {128'd0, bus_a.wr_data}, {12'd0, bus_a.wr_rn}, int'(defer_a));
    end
    if (exp_b.size() > 0) begin
      e = exp_b.pop_front();
      checkOutput("B", 4, e, bus_b.unit_ready, bus_b.wr_en,
                  bus_b.wr_data, bus_b.wr_rn, int'(defer_b));
    end
  end

  task automatic clearStim();
    for (int i = 0; i < NU; i++) begin
      sv[i] = 0; sd[i] = 0; sdat[i] = '0; sdat2[i] = '0; srn[i] = '0; srn2[i] = '0;
    end
  endtask

  task automatic setChan(input int ch, input logic [5:0] rn, input logic [63:0] d,
                         input logic dual, input logic [5:0] rn2, input logic [63:0] d2);
    sv[ch] = 1'b1; srn[ch] = rn; sdat[ch] = d; sd[ch] = dual; srn2[ch] = rn2; sdat2[ch] = d2;
  endtask

  task automatic resetCycles(input int n);
    rst_drv = 1'b0;
    for (int i = 0; i < n; i++) applyStimulus();
    rst_drv = 1'b1;
  endtask

  initial begin
    bus_a.unit_valid = '0; bus_a.unit_dual = '0; bus_a.unit_data = '0;
    bus_a.unit_data2 = '0; bus_a.unit_rn = '0; bus_a.unit_rn2 = '0;
    bus_b.unit_valid = '0; bus_b.unit_dual = '0; bus_b.unit_data = '0;
    bus_b.unit_data2 = '0; bus_b.unit_rn = '0; bus_b.unit_rn2 = '0;
    for (int k = 0; k < 2; k++) begin mn[k] = 0; mrr[k] = 0; end
    clearStim();
    setChan(0, 6'd3, 64'h55, 1'b1, 6'd4, 64'h66);
    resetCycles(3);

    // Single write on channel 2
    clearStim();
    setChan(2, 6'd5, 64'hAB, 1'b0, 6'd0, 64'h0);
    applyStimulus();
    clearStim();
    applyStimulus();

    // Round-robin with all channels valid
    resetCycles(1);
    for (int c = 0; c < 3; c++) begin
      clearStim();
      for (int i = 0; i < NU; i++) setChan(i, 6'(10 + i), 64'(100 + 10 * c + i), 1'b0, 6'd0, 64'h0);
      applyStimulus();
    end

    // Dual write on channel 3, then drain
    resetCycles(1);
    clearStim();
    setChan(3, 6'd7, 64'h11, 1'b1, 6'd8, 64'h22);
    applyStimulus();
    clearStim();
    applyStimulus();
    applyStimulus();

    // r0 suppression
    resetCycles(1);
    clearStim();
    setChan(1, 6'd0, 64'hDEAD, 1'b0, 6'd0, 64'h0);
    setChan(2, 6'd9, 64'hBEEF, 1'b0, 6'd0, 64'h0);
    applyStimulus();

    // Every channel dual: fills the FIFOs, exercises full-FIFO pop+push and dual blocking
    for (int c = 0; c < 4; c++) begin
      clearStim();
      for (int i = 0; i < NU; i++)
        setChan(i, 6'(20 + i), 64'(200 + i + c), 1'b1, 6'(40 + i), 64'(300 + i + c));
      applyStimulus();
    end

    // Reset with deferred writes pending, then idle
    resetCycles(2);
    clearStim();
    for (int c = 0; c < 3; c++) applyStimulus();

    // Randomized traffic with occasional resets
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NU; i++) begin
        sv[i]    = ($urandom_range(0, 3) != 0);
        sd[i]    = ($urandom_range(0, 2) == 0);
        srn[i]   = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
        srn2[i]  = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
        sdat[i]  = {$urandom, $urandom};
        sdat2[i] = {$urandom, $urandom};
      end
      rst_drv = ($urandom_range(0, 99) != 0);
      applyStimulus();
    end
    rst_drv = 1'b1;
    clearStim();
    for (int c = 0; c < 4; c++) applyStimulus();

    @(posedge clk);
    @(negedge clk);
    #1;
    cmp("drain_a", 64'(exp_a.size()), 64'd0);
    cmp("drain_b", 64'(exp_b.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
